// File: rtl/fx_pkg.sv
// Shared types and constants for the FX fixed-to-float front end and FX function unit.
package fx_pkg;

    localparam int FP_BIAS   = 127;
    localparam int FP_MANT_W = 23;
    localparam int FP_EXP_W  = 8;
    localparam int LATENCY   = 3;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W-1:0] mant;
    } fx_float_t;

    typedef struct packed {
        logic        valid;
        logic        sign;
        logic [4:0]  frac;
        logic [31:0] mag;
    } fx_s1_t;

    // Exponent is stored already biased; the zero flag overrides it in packing.
    typedef struct packed {
        logic                valid;
        logic                sign;
        logic                zero;
        logic [FP_EXP_W-1:0] exp;
        logic [31:0]         norm;
    } fx_s2_t;

endpackage

// File: rtl/fx_fixed_to_float_if.sv
// Custom-instruction start/done bus between the Nios issue side and the converter.
interface fx_fixed_to_float_if;

    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic        done;
    logic [31:0] result;

    modport master (output start, dataa, datab, input done, result);
    modport slave  (input start, dataa, datab, output done, result);

endinterface

// File: rtl/fx_lzc32.sv
// Combinational 32-bit leading-zero counter; an all-zero input reports 32.
module fx_lzc32 (
    input  logic [31:0] value,
    output logic [5:0]  count
);

    // Ascending scan so the highest set bit is the last assignment to win.
    always_comb begin
        count = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (value[i]) count = 6'(31 - i);
        end
    end

endmodule

// File: rtl/fx_fixed_to_float.sv
// Three-stage signed fixed-point (dataa * 2^-F) to IEEE-754 single converter,
// round to nearest even, with a global clk_en stall.
module fx_fixed_to_float
    import fx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    fx_fixed_to_float_if.slave bus
);

    fx_s1_t      s1;
    fx_s2_t      s2;
    logic        done_r;
    logic [31:0] result_r;

    logic [31:0] mag_c;
    logic        unused_datab;

    assign unused_datab = ^bus.datab[31:5];

    // Unsigned negate also maps -2^31 onto 0x80000000.
    always_comb begin
        mag_c = bus.dataa;
        if (bus.dataa[31]) mag_c = ~bus.dataa + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
        end else if (clk_en) begin
            s1.valid <= bus.start;
            s1.sign  <= bus.dataa[31];
            s1.frac  <= bus.datab[4:0];
            s1.mag   <= mag_c;
        end
    end

    logic [5:0]          lz;
    logic [31:0]         norm_c;
    logic [FP_EXP_W-1:0] exp_c;

    fx_lzc32 u_lzc (
        .value (s1.mag),
        .count (lz)
    );

    always_comb begin
        norm_c = s1.mag << lz[4:0];
        exp_c  = 8'(FP_BIAS + 31) - {3'd0, lz[4:0]} - {3'd0, s1.frac};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2 <= '0;
        end else if (clk_en) begin
            s2.valid <= s1.valid;
            s2.sign  <= s1.sign;
            s2.zero  <= lz[5];
            s2.exp   <= exp_c;
            s2.norm  <= norm_c;
        end
    end

    logic [FP_MANT_W-1:0] mant;
    logic                 guard;
    logic                 sticky;
    logic                 round_up;
    logic [FP_MANT_W:0]   mant_sum;
    fx_float_t            fp_out;

    // A carry out of the mantissa leaves it all-zero and bumps the exponent.
    always_comb begin
        mant        = s2.norm[30:8];
        guard       = s2.norm[7];
        sticky      = |s2.norm[6:0];
        round_up    = guard & (sticky | mant[0]);
        mant_sum    = {1'b0, mant} + {{FP_MANT_W{1'b0}}, round_up};
        fp_out.sign = s2.sign;
        fp_out.exp  = s2.exp + {7'd0, mant_sum[FP_MANT_W]};
        fp_out.mant = mant_sum[FP_MANT_W-1:0];
        if (s2.zero) fp_out = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_r   <= 1'b0;
            result_r <= '0;
        end else if (clk_en) begin
            done_r <= s2.valid;
            if (s2.valid) result_r <= fp_out;
        end
    end

    assign bus.done   = done_r;
    assign bus.result = result_r;

endmodule

// File: tb/tb_fx_fixed_to_float.sv
// Scoreboard bench for fx_fixed_to_float: directed vectors, stall and reset cases.
module tb_fx_fixed_to_float;
    import fx_pkg::*;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic clk_en = 1'b0;

    fx_fixed_to_float_if bus ();

    fx_fixed_to_float dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] expv;
        int          issue;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   en_cnt = 0;

    always @(posedge clk) if (clk_en) en_cnt <= en_cnt + 1;

    // Consumer samples done only in enabled cycles.
    always @(negedge clk) begin
        exp_t e;
        if (rst && clk_en && bus.done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: result=%h but no operation outstanding", bus.result);
            end else begin
                e = sb.pop_front();
                if (bus.result !== e.expv) begin
                    errors++;
                    $display("FAIL %s: result=%h expected=%h", e.name, bus.result, e.expv);
                end
                checks++;
                if (en_cnt - e.issue != LATENCY) begin
                    errors++;
                    $display("FAIL %s_latency: cycles=%0d expected=%0d", e.name, en_cnt - e.issue, LATENCY);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, act, expv);
        end
    endtask

    // Drives one start for one cycle, then scrambles operands to prove edge sampling.
    task automatic issue(input logic [31:0] a, input logic [4:0] f,
                         input logic [31:0] expv, input string name);
        exp_t e;
        bus.start = 1'b1;
        bus.dataa = a;
        bus.datab = {27'h7ABCDE1, f};
        if (clk_en) begin
            e.expv  = expv;
            e.issue = en_cnt;
            e.name  = name;
            sb.push_back(e);
        end
        step(1);
        bus.start = 1'b0;
        bus.dataa = ~a;
        bus.datab = ~bus.datab;
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 20 && sb.size() != 0; k++) step(1);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: outstanding=%0d expected=0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.dataa = '0;
        bus.datab = '0;
        rst       = 1'b0;
        #1;
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        chk("reset_result", bus.result, 32'h0000_0000);
        step(2);
        rst    = 1'b1;
        clk_en = 1'b1;
        step(1);

        issue(32'd64, 5'd0, 32'h4280_0000, "basic_64");
        wait_drain("basic_64");
        chk("done_pulse", {31'd0, bus.done}, 32'd0);
        chk("result_hold", bus.result, 32'h4280_0000);
        issue(32'hFFFF_FFFF, 5'd0, 32'hBF80_0000, "basic_m1");
        wait_drain("basic_m1");

        issue(32'h8000_0000, 5'd0,  32'hCF00_0000, "ext_min");
        issue(32'h7FFF_FFFF, 5'd0,  32'h4F00_0000, "ext_max_carry");
        issue(32'h0000_0001, 5'd31, 32'h3000_0000, "ext_one_f31");
        issue(32'h0000_0000, 5'd17, 32'h0000_0000, "ext_zero_f17");
        issue(32'h0100_0001, 5'd0,  32'h4B80_0000, "rnd_tie_even");
        issue(32'h0100_0003, 5'd0,  32'h4B80_0002, "rnd_tie_up");
        issue(32'h0100_0005, 5'd0,  32'h4B80_0002, "rnd_tie_down");
        issue(32'h00C0_0000, 5'd24, 32'h3F40_0000, "frac_0p75");
        wait_drain("extremes_rounding");

        issue(32'd1, 5'd0, 32'h3F80_0000, "stream_1");
        issue(32'd2, 5'd0, 32'h4000_0000, "stream_2");
        issue(32'd3, 5'd0, 32'h4040_0000, "stream_3");
        issue(32'd4, 5'd0, 32'h4080_0000, "stream_4");
        issue(32'd5, 5'd0, 32'h40A0_0000, "stream_5");
        wait_drain("stream");

        issue(32'd10,   5'd0, 32'h4120_0000, "stall_10");
        issue(32'd100,  5'd0, 32'h42C8_0000, "stall_100");
        issue(32'd1000, 5'd0, 32'h447A_0000, "stall_1000");
        clk_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("stall_done_%0d", k), {31'd0, bus.done}, 32'd1);
            chk($sformatf("stall_result_%0d", k), bus.result, 32'h4120_0000);
            if (k == 1) begin
                bus.start = 1'b1;
                bus.dataa = 32'd7;
            end
            if (k == 2) bus.start = 1'b0;
            step(1);
        end
        clk_en = 1'b1;
        wait_drain("stall");

        issue(32'd5, 5'd0, 32'h40A0_0000, "rst_inflight_a");
        issue(32'd6, 5'd0, 32'h40C0_0000, "rst_inflight_b");
        rst = 1'b0;
        sb.delete();
        #1;
        chk("rst_mid_done", {31'd0, bus.done}, 32'd0);
        chk("rst_mid_result", bus.result, 32'h0000_0000);
        step(1);
        rst = 1'b1;
        step(6);
        chk("rst_no_done", {31'd0, bus.done}, 32'd0);
        issue(32'hFFFF_FFF8, 5'd1, 32'hC080_0000, "after_rst_m8_f1");
        wait_drain("after_rst");
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
